// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART constants and FIFO fill-level helper.
//  Revision    : 1.0  initial release
// ============================================================================
package uart_pkg;

    localparam int UART_DATA_W      = 8;
    localparam int UART_FIFO_DEPTH  = 16;
    localparam int UART_FIFO_ADDR_W = 4;

    // Pointers carry one extra wrap bit, so the difference is taken modulo 2**(addr_w+1).
    function automatic logic [31:0] fifo_count(input logic [31:0] wr_pt,
                                               input logic [31:0] rd_pt,
                                               input int          addr_w);
        logic [31:0] mask;
        mask = (32'd1 << (addr_w + 1)) - 32'd1;
        return (wr_pt - rd_pt) & mask;
    endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/fifo_rx_mem.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_rx_mem
//  Description : DEPTH x ENTRY_W register array, one synchronous write port
//                and one registered read port (read register resettable).
//  Revision    : 1.0  initial release
// ============================================================================
module fifo_rx_mem #(
    parameter int ENTRY_W = 8,
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [ENTRY_W-1:0] wr_data,
    input  logic               rd_en,
    input  logic [ADDR_W-1:0]  rd_addr,
    output logic [ENTRY_W-1:0] rd_data
);

    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [ENTRY_W-1:0] r_rd_data;

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Same-address read and write returns the old entry, which is the one being consumed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_data <= '0;
        end else if (rd_en) begin
            r_rd_data <= r_mem[rd_addr];
        end
    end

    assign rd_data = r_rd_data;

endmodule : fifo_rx_mem
`default_nettype wire

// File: rtl/fifo_rx.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_rx
//  Description : UART receive byte FIFO with full/empty/count and sticky
//                overrun. Optional macro FIFO_RX_FRAME_ERR_EN stores a
//                frame-error bit per entry and returns it on data_err.
//  Revision    : 1.0  initial release
// ============================================================================
module fifo_rx
    import uart_pkg::*;
#(
    parameter int DATA_W = UART_DATA_W,
    parameter int DEPTH  = UART_FIFO_DEPTH,
    parameter int ADDR_W = UART_FIFO_ADDR_W
) (
    input  logic              clk_fifo_rx,
    input  logic              rst_fifo_rx_n,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_done,
    input  logic              rd_req,
    input  logic              clr_overrun,
`ifdef FIFO_RX_FRAME_ERR_EN
    input  logic              rx_frame_err,
`endif
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              fifo_rx_full,
    output logic              fifo_rx_empty,
    output logic [ADDR_W:0]   fifo_rx_count,
`ifdef FIFO_RX_FRAME_ERR_EN
    output logic              data_err,
`endif
    output logic              overrun
);

`ifdef FIFO_RX_FRAME_ERR_EN
    localparam int c_ENTRY_W = DATA_W + 1;
`else
    localparam int c_ENTRY_W = DATA_W;
`endif
    localparam logic [ADDR_W:0] c_PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [ADDR_W:0]    r_wr_pt;
    logic [ADDR_W:0]    r_rd_pt;
    logic [ADDR_W:0]    r_count;
    logic               r_full;
    logic               r_empty;
    logic               r_overrun;
    logic               r_data_valid;

    logic               w_rd_acc;
    logic               w_wr_acc;
    logic               w_ovr_evt;
    logic [ADDR_W:0]    w_wr_pt_nxt;
    logic [ADDR_W:0]    w_rd_pt_nxt;
    logic [ADDR_W:0]    w_count_nxt;
    logic               w_full_nxt;
    logic               w_empty_nxt;
    logic [c_ENTRY_W-1:0] w_wr_entry;
    logic [c_ENTRY_W-1:0] w_rd_entry;

`ifdef FIFO_RX_FRAME_ERR_EN
    assign w_wr_entry = {rx_frame_err, rx_data};
    assign data_err   = w_rd_entry[DATA_W];
`else
    assign w_wr_entry = rx_data;
`endif

    // No bypass: acceptance uses only the flags registered at the start of the cycle.
    assign w_rd_acc  = rd_req && !r_empty;
    assign w_wr_acc  = rx_done && (!r_full || w_rd_acc);
    assign w_ovr_evt = rx_done && r_full && !w_rd_acc;

    assign w_wr_pt_nxt = w_wr_acc ? (r_wr_pt + c_PTR_ONE) : r_wr_pt;
    assign w_rd_pt_nxt = w_rd_acc ? (r_rd_pt + c_PTR_ONE) : r_rd_pt;
    assign w_count_nxt = (ADDR_W+1)'(fifo_count(32'(w_wr_pt_nxt), 32'(w_rd_pt_nxt), ADDR_W));
    assign w_empty_nxt = (w_wr_pt_nxt == w_rd_pt_nxt);
    assign w_full_nxt  = (w_wr_pt_nxt[ADDR_W] != w_rd_pt_nxt[ADDR_W]) &&
                         (w_wr_pt_nxt[ADDR_W-1:0] == w_rd_pt_nxt[ADDR_W-1:0]);

    always_ff @(posedge clk_fifo_rx) begin
        if (!rst_fifo_rx_n) begin
            r_wr_pt      <= '0;
            r_rd_pt      <= '0;
            r_count      <= '0;
            r_full       <= 1'b0;
            r_empty      <= 1'b1;
            r_overrun    <= 1'b0;
            r_data_valid <= 1'b0;
        end else begin
            r_wr_pt      <= w_wr_pt_nxt;
            r_rd_pt      <= w_rd_pt_nxt;
            r_count      <= w_count_nxt;
            r_full       <= w_full_nxt;
            r_empty      <= w_empty_nxt;
            r_data_valid <= w_rd_acc;
            // A new drop in the same cycle as a clear keeps the flag set.
            if (w_ovr_evt) begin
                r_overrun <= 1'b1;
            end else if (clr_overrun) begin
                r_overrun <= 1'b0;
            end
        end
    end

    fifo_rx_mem #(
        .ENTRY_W (c_ENTRY_W),
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W)
    ) u_mem (
        .clk     (clk_fifo_rx),
        .rst_n   (rst_fifo_rx_n),
        .wr_en   (w_wr_acc),
        .wr_addr (r_wr_pt[ADDR_W-1:0]),
        .wr_data (w_wr_entry),
        .rd_en   (w_rd_acc),
        .rd_addr (r_rd_pt[ADDR_W-1:0]),
        .rd_data (w_rd_entry)
    );

    assign data_out      = w_rd_entry[DATA_W-1:0];
    assign data_valid    = r_data_valid;
    assign fifo_rx_full  = r_full;
    assign fifo_rx_empty = r_empty;
    assign fifo_rx_count = r_count;
    assign overrun       = r_overrun;

endmodule : fifo_rx
`default_nettype wire
